pipe_reg_if_id_hs: RTL and testbench
====================================

Name: pipe_reg_if_id_hs

Overview:
- Parametrised IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Sits between instruction fetch and decode.
- Lets decode stall without a combinational ready path back into fetch.
- Supports a synchronous flush for branch redirect; a flushed or empty slot presents a NOP instruction to decode.

Parameters:
- PC_W, 8, program counter width in bits.
- INSTR_W, 16, instruction width in bits.
- NOP_INSTR, {INSTR_W{1'b0}}, instruction value presented on out_instr when out_valid=0.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents a valid PC/instruction.
- in_ready  out  1  block can accept; registered (depends only on state).
- in_pc  in  PC_W  fetched PC.
- in_instr  in  INSTR_W  fetched instruction.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode accepts the entry this cycle.
- out_pc  out  PC_W  PC of head entry.
- out_instr  out  INSTR_W  instruction of head entry; NOP_INSTR when out_valid=0.
- flush  in  1  synchronous discard of all held entries.
- occupancy  out  2  entries held, 0..2.

Behaviour:
- Reset (reset_n low, asynchronous): state EMPTY.
  - Reset output values: out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1, occupancy=0.
  - Skid entry cleared to pc=0, instr=NOP_INSTR.
- Reset mid-operation: all held entries are lost immediately, without waiting for a clock edge.
- Handshake definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Data may only change on the sampling edge; out_* are stable while out_valid=1 and out_ready=0.
- Storage: main register (drives out_*) and skid register.
- State machine (next state on rising clk):
  - EMPTY (occ 0, in_ready=1):
    - accept -> ONE, main <= input.
    - otherwise stay.
  - ONE (occ 1, in_ready=1):
    - pop & !accept -> EMPTY.
    - pop & accept -> ONE, main <= input.
    - !pop & accept -> FULL, skid <= input, main held.
    - neither -> stay.
  - FULL (occ 2, in_ready=0):
    - pop -> ONE, main <= skid. in_valid is ignored because in_ready=0.
    - otherwise stay.
- Latency: an entry accepted in EMPTY is on out_* one cycle later. Throughput is 1 entry/cycle when out_ready is held high.
- Ordering: strict FIFO; the skid entry is never presented before the main entry.
- Output values:
  - out_valid = (state != EMPTY).
  - out_instr = NOP_INSTR whenever state is EMPTY.
  - out_pc retains its last value when EMPTY; it is 0 after reset.
- Flush:
  - Highest priority among clocked events; next state is EMPTY regardless of accept or pop.
  - A same-cycle accept is discarded.
  - A same-cycle pop still counts as consumed by decode; the block does nothing further with it.
  - in_ready=1 on the cycle after a flush.
- Simultaneous pop & accept in FULL is impossible (in_ready=0).
- in_valid is allowed to drop without being accepted; the block has no upstream hold requirement.
- Widths are pass-through; the block performs no arithmetic on PC or instruction.
- occupancy is derived from the state encoding and is registered.

Decomposition:
- Shared package pipe_pkg: state enum (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and default NOP constant. Other pipeline-register generations (ID/EX, EX/MEM) reuse it.
- One natural sub-module: pipe_entry_reg. It holds the {pc, instr} pair with a load enable, async active-low reset and parametrised reset value.
- pipe_entry_reg is instantiated twice (main, skid).

Test Plan:
- Reset: assert reset_n=0 mid-FULL with entries 0x10/0xABCD and 0x11/0x1234 -> immediately out_valid=0, out_instr=NOP_INSTR, out_pc=0, occupancy=0, in_ready=1.
- Streaming: out_ready=1, feed pc 0x00..0x07 with instr 0x1000+pc one per cycle -> same sequence on out_*, one-cycle latency, no bubbles, occupancy stays 1.
- Back-pressure: out_ready=0, feed pc 0x20 then 0x21 -> occupancy 2, in_ready=0 and pc 0x22 held off. Release out_ready -> 0x20, 0x21, 0x22 emerge in order.
- Flush while FULL with accept attempt: holding 0x30/0x31, assert flush with in_valid=1 pc 0x32 -> next cycle EMPTY, out_instr=NOP_INSTR, in_ready=1, and 0x32 never appears.
- Pop+accept in ONE: main=0x40, out_ready=1, in_valid=1 pc 0x41 -> next cycle out_pc=0x41, occupancy=1.
- Parameter sweep: PC_W=16, INSTR_W=32, NOP_INSTR=0x00000013 -> empty slots show 0x00000013, and full-width values 0xFFFF/0xFFFFFFFF pass through unaltered.

Source files
------------

// File: rtl/pipe_pkg.sv
// Types and constants shared by the pipeline-register family (IF/ID, ID/EX, EX/MEM).
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Fill bit for the default NOP; stages replicate it to their instruction width.
  localparam logic NOP_FILL_BIT = 1'b0;

  // The state encoding is chosen so that it doubles as the entry count.
  function automatic logic [1:0] occ_of(input pipe_state_e s);
    return logic'(s == ONE) ? 2'd1 : (s == FULL) ? 2'd2 : 2'd0;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One {pc, instr} slot with load enable and async active-low reset to a programmable value.
module pipe_entry_reg #(
  parameter int                 PC_W      = 8,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] RST_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [PC_W-1:0]    d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  output logic [PC_W-1:0]    q_pc,
  output logic [INSTR_W-1:0] q_instr
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_pc    <= '0;
      q_instr <= RST_INSTR;
    end else if (load) begin
      q_pc    <= d_pc;
      q_instr <= d_instr;
    end
  end

endmodule

// File: rtl/pipe_reg_if_id_hs.sv
// IF/ID pipeline register: valid/ready handshake with a 2-entry skid so in_ready is registered.
module pipe_reg_if_id_hs
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = 8,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{NOP_FILL_BIT}}
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               flush,
  output logic [1:0]         occupancy
);

  pipe_state_e        state, state_nxt;
  logic               accept, pop;
  logic               main_ld, main_from_skid, skid_ld;
  logic [PC_W-1:0]    main_pc, skid_pc, main_d_pc;
  logic [INSTR_W-1:0] main_instr, skid_instr, main_d_instr;

  // Ready and valid come straight from the state register; no comb path from out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = occ_of(state);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt = ONE;
        main_ld   = 1'b1;
      end
      ONE: begin
        if (pop && accept)   main_ld   = 1'b1;
        else if (pop)        state_nxt = EMPTY;
        else if (accept) begin
          state_nxt = FULL;
          skid_ld   = 1'b1;
        end
      end
      FULL: if (pop) begin
        state_nxt      = ONE;
        main_ld        = 1'b1;
        main_from_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins: drop everything, including a same-cycle accept.
    if (flush) begin
      state_nxt = EMPTY;
      main_ld   = 1'b0;
      skid_ld   = 1'b0;
    end
  end

  assign main_d_pc    = main_from_skid ? skid_pc    : in_pc;
  assign main_d_instr = main_from_skid ? skid_instr : in_instr;

  pipe_entry_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RST_INSTR(NOP_INSTR)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_ld),
    .d_pc    (main_d_pc),
    .d_instr (main_d_instr),
    .q_pc    (main_pc),
    .q_instr (main_instr)
  );

  pipe_entry_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RST_INSTR(NOP_INSTR)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_ld),
    .d_pc    (in_pc),
    .d_instr (in_instr),
    .q_pc    (skid_pc),
    .q_instr (skid_instr)
  );

  // out_pc keeps the last head PC when empty; only the instruction is masked to NOP.
  assign out_pc    = main_pc;
  assign out_instr = (state == EMPTY) ? NOP_INSTR : main_instr;

endmodule

// File: tb/tb_pipe_reg_if_id_hs.sv
// Directed bench for pipe_reg_if_id_hs: default widths plus a wide/non-zero-NOP instance.
module tb_pipe_reg_if_id_hs;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [7:0]  in_pc, out_pc;
  logic [15:0] in_instr, out_instr;
  logic [1:0]  occupancy;

  // wide instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [15:0] b_in_pc, b_out_pc;
  logic [31:0] b_in_instr, b_out_instr;
  logic [1:0]  b_occupancy;

  int n_cmp = 0;
  int n_err = 0;

  pipe_reg_if_id_hs dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .flush(flush), .occupancy(occupancy)
  );

  pipe_reg_if_id_hs #(.PC_W(16), .INSTR_W(32), .NOP_INSTR(32'h0000_0013)) dut_w (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_instr(b_in_instr),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr),
    .flush(b_flush), .occupancy(b_occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] pc, input logic [15:0] ins);
    in_valid = v;
    in_pc    = pc;
    in_instr = ins;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 8'h00, 16'h0000);
    out_ready = 1'b0; flush = 1'b0;
    b_in_valid = 1'b0; b_in_pc = '0; b_in_instr = '0; b_out_ready = 1'b0; b_flush = 1'b0;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc",    64'(out_pc),    64'h00);
    chk("rst_instr", 64'(out_instr), 64'h0000);
    chk("rst_ready", 64'(in_ready),  64'd1);
    chk("rst_occ",   64'(occupancy), 64'd0);
    chk("w_rst_instr", 64'(b_out_instr), 64'h13);
    reset_n = 1'b1;
    step();

    // streaming: one-cycle latency, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 16'h1000 + 16'(i));
      step();
      chk($sformatf("str_pc%0d", i),    64'(out_pc),    64'(i));
      chk($sformatf("str_instr%0d", i), 64'(out_instr), 64'h1000 + 64'(i));
      chk($sformatf("str_occ%0d", i),   64'(occupancy), 64'd1);
      chk($sformatf("str_vld%0d", i),   64'(out_valid), 64'd1);
    end
    drive(1'b0, 8'h00, 16'h0000);
    step();
    chk("str_drain_occ",   64'(occupancy), 64'd0);
    chk("str_drain_instr", 64'(out_instr), 64'h0000);
    chk("str_drain_pc",    64'(out_pc),    64'h07);

    // back-pressure into the skid
    out_ready = 1'b0;
    drive(1'b1, 8'h20, 16'h2020);
    step();
    chk("bp_occ1", 64'(occupancy), 64'd1);
    chk("bp_pc1",  64'(out_pc),    64'h20);
    drive(1'b1, 8'h21, 16'h2121);
    step();
    chk("bp_occ2",  64'(occupancy), 64'd2);
    chk("bp_ready", 64'(in_ready),  64'd0);
    chk("bp_hold",  64'(out_pc),    64'h20);
    drive(1'b1, 8'h22, 16'h2222);
    step();
    chk("bp_occ2b",  64'(occupancy), 64'd2);
    chk("bp_pc20",   64'(out_pc),    64'h20);
    chk("bp_ins20",  64'(out_instr), 64'h2020);
    out_ready = 1'b1;
    step();
    chk("bp_pc21",  64'(out_pc),    64'h21);
    chk("bp_ins21", 64'(out_instr), 64'h2121);
    chk("bp_occ_a", 64'(occupancy), 64'd1);
    step();
    chk("bp_pc22",  64'(out_pc),    64'h22);
    chk("bp_ins22", 64'(out_instr), 64'h2222);
    drive(1'b0, 8'h00, 16'h0000);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // flush while FULL with an accept attempt
    out_ready = 1'b0;
    drive(1'b1, 8'h30, 16'h3030); step();
    drive(1'b1, 8'h31, 16'h3131); step();
    chk("fl_full", 64'(occupancy), 64'd2);
    drive(1'b1, 8'h32, 16'h3232);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 8'h00, 16'h0000);
    chk("fl_occ",   64'(occupancy), 64'd0);
    chk("fl_vld",   64'(out_valid), 64'd0);
    chk("fl_instr", 64'(out_instr), 64'h0000);
    chk("fl_ready", 64'(in_ready),  64'd1);
    chk("fl_pc",    64'(out_pc),    64'h30);
    out_ready = 1'b1;
    step(); step();
    chk("fl_no32_vld", 64'(out_valid), 64'd0);
    chk("fl_no32_pc",  64'(out_pc),    64'h30);

    // pop + accept in ONE
    out_ready = 1'b0;
    drive(1'b1, 8'h40, 16'h4040); step();
    chk("pa_pc40", 64'(out_pc), 64'h40);
    out_ready = 1'b1;
    drive(1'b1, 8'h41, 16'h4141); step();
    chk("pa_pc41",  64'(out_pc),    64'h41);
    chk("pa_ins41", 64'(out_instr), 64'h4141);
    chk("pa_occ",   64'(occupancy), 64'd1);
    drive(1'b0, 8'h00, 16'h0000); step();
    chk("pa_empty", 64'(occupancy), 64'd0);

    // async reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 8'h10, 16'hABCD); step();
    drive(1'b1, 8'h11, 16'h1234); step();
    drive(1'b0, 8'h00, 16'h0000);
    chk("ar_full", 64'(occupancy), 64'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_instr", 64'(out_instr), 64'h0000);
    chk("ar_pc",    64'(out_pc),    64'h00);
    chk("ar_occ",   64'(occupancy), 64'd0);
    chk("ar_ready", 64'(in_ready),  64'd1);
    #1 reset_n = 1'b1;
    // skid must not resurface after reset
    out_ready = 1'b1;
    step(); step();
    chk("ar_stay_empty", 64'(out_valid), 64'd0);

    // wide instance: full-width values pass through, empty shows 0x13
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_pc = 16'hFFFF; b_in_instr = 32'hFFFF_FFFF;
    step();
    chk("w_pc",    64'(b_out_pc),    64'hFFFF);
    chk("w_instr", 64'(b_out_instr), 64'hFFFF_FFFF);
    chk("w_vld",   64'(b_out_valid), 64'd1);
    b_in_valid = 1'b0;
    step();
    chk("w_nop",    64'(b_out_instr), 64'h0000_0013);
    chk("w_pc_ret", 64'(b_out_pc),    64'hFFFF);
    chk("w_occ",    64'(b_occupancy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
